spi_slave_fsm: RTL
==================

SPI_SLAVE_FSM -- requirements
Module: spi_slave_fsm

Interface
REQ-001 Parameter ADDR_W, default 7, memory address width (address bits per command byte).
REQ-002 Parameter DATA_W, default 8, data byte width.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cs_n  input  1  conditioned chip select, active low, from the input conditioner.
REQ-006 sclk_pos  input  1  one-clk pulse at each conditioned SCLK rising edge.
REQ-007 sclk_neg  input  1  one-clk pulse at each conditioned SCLK falling edge.
REQ-008 mosi  input  1  conditioned MOSI level.
REQ-009 mem_rdata  input  DATA_W  asynchronous read data for mem_addr.
REQ-010 mem_addr  output  ADDR_W  latched command address.
REQ-011 mem_wdata  output  DATA_W  received write byte.
REQ-012 mem_we  output  1  one-clk memory write strobe.
REQ-013 miso  output  1  serial read data, MSB first.
REQ-014 miso_oe  output  1  MISO tri-state enable, high only while driving read data.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, GET_CMD, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT, DONE.
REQ-017 IDLE -> GET_CMD on the first clk with cs_n==0; bit counter cleared to 0.
REQ-018 GET_CMD: each sclk_pos shifts mosi into command register LSB (shift left); after ADDR_W+1 bits, upper ADDR_W bits latch to mem_addr, last bit is R/W (1=read).
REQ-019 Command complete with R/W=1 -> READ_LOAD; R/W=0 -> WRITE_SHIFT; bit counter cleared.
REQ-020 READ_LOAD lasts exactly one clk: tx register <= mem_rdata, then READ_SHIFT.
REQ-021 In READ_SHIFT, miso = tx[DATA_W-1] and miso_oe=1; each sclk_neg shifts tx left by one; the DATA_W-th sclk_neg -> DONE.
REQ-022 WRITE_SHIFT: each sclk_pos shifts mosi into rx register; after DATA_W bits -> WRITE_COMMIT.
REQ-023 WRITE_COMMIT lasts one clk: mem_we=1, mem_wdata=rx; then DONE.
REQ-024 DONE: miso_oe=0, ignores SCLK pulses, -> IDLE when cs_n==1.
REQ-025 cs_n==1 in GET_CMD, READ_LOAD, READ_SHIFT or WRITE_SHIFT SHALL abort to IDLE next clk, no mem_we, miso_oe=0 that same next clk.
REQ-026 cs_n==1 during WRITE_COMMIT SHALL NOT cancel the write; transition is to IDLE instead of DONE.
REQ-027 sclk_pos and sclk_neg high together: only the edge relevant to the current state acts; the other is ignored.
REQ-028 SCLK pulses in IDLE are ignored; bit counter width is clog2(DATA_W+1) and never wraps within a phase.
REQ-029 miso SHALL be 0 whenever miso_oe==0.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, counters 0, shift registers 0, mem_addr 0, mem_wdata 0, mem_we 0, miso 0, miso_oe 0, busy 0.
REQ-031 Reset asserted mid-transaction SHALL discard all partial command/data with no write strobe; after release, a new transaction starts only on cs_n==0.

Structure
REQ-032 Shared package spi_pkg SHALL hold the state enum and default ADDR_W/DATA_W constants.
REQ-033 One sub-module spi_shiftreg (parallel load, serial in, serial out, shift enable) SHALL be instantiated for both rx and tx paths.

Verification
REQ-034 Write: cs_n low, shift 0x2A+W(0) then 0xC3 on sclk_pos -> single mem_we pulse, mem_addr=0x2A, mem_wdata=0xC3, then DONE until cs_n high.
REQ-035 Read: mem_rdata=0x96 for addr 0x05, command 0x05+R(1) -> miso_oe rises one clk after 8th sclk_pos, miso sequence 1,0,0,1,0,1,1,0 across sclk_neg edges, then miso_oe=0.
REQ-036 Abort: cs_n high after 4 data bits of a write -> IDLE next clk, mem_we never asserted.
REQ-037 cs_n high in same clk as WRITE_COMMIT -> mem_we still pulses once, state IDLE afterward.
REQ-038 rst_n low during READ_SHIFT -> all outputs 0 asynchronously; post-reset write of 0x11 to addr 0x7F completes correctly.
REQ-039 SCLK pulses with cs_n high for 16 edges -> busy, mem_we, miso_oe remain 0.

Source files
------------

// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared SPI slave FSM state encoding, default widths and helpers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_GET_CMD      = 3'd1,
        ST_READ_LOAD    = 3'd2,
        ST_READ_SHIFT   = 3'd3,
        ST_WRITE_SHIFT  = 3'd4,
        ST_WRITE_COMMIT = 3'd5,
        ST_DONE         = 3'd6
    } spi_state_t;

    // The counter must hold ADDR_W (command phase) and DATA_W-1 (data phase).
    function automatic int cnt_width(input int addr_w, input int data_w);
        int m;
        m = (addr_w + 1 > data_w) ? addr_w + 1 : data_w;
        return $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_shiftreg.sv
// ============================================================================
// Module      : spi_shiftreg
// Description : Shift register with clear, parallel load and MSB-first serial I/O.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_shiftreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_pdata,
    input  logic             i_shift,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_pdata,
    output logic             o_sout
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_clr) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_pdata;
        end else if (i_shift) begin
            r_data <= {r_data[WIDTH-2:0], i_sin};
        end
    end

    assign o_pdata = r_data;
    assign o_sout  = r_data[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/spi_slave_fsm.sv
// ============================================================================
// Module      : spi_slave_fsm
// Description : SPI slave protocol FSM: command/address, byte read and write.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_slave_fsm
    import spi_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              sclk_pos,
    input  logic              sclk_neg,
    input  logic              mosi,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              miso,
    output logic              miso_oe,
    output logic              busy
);

    localparam int               CNT_W       = cnt_width(ADDR_W, DATA_W);
    localparam logic [CNT_W-1:0] c_cmd_last  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] c_data_last = CNT_W'(DATA_W - 1);

    spi_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_cmd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic              r_miso_oe;

    logic              w_sr_clr;
    logic              w_rx_shift;
    logic              w_tx_load;
    logic              w_tx_shift;
    logic [DATA_W-1:0] w_rx_pdata;
    logic              w_rx_sout;
    logic [DATA_W-1:0] w_tx_pdata;
    logic              w_tx_sout;
    logic              w_unused;

    // Data registers are wiped when a new transaction opens, so the last
    // written byte stays visible on mem_wdata until then.
    assign w_sr_clr   = (r_state == ST_IDLE)        && !cs_n;
    assign w_rx_shift = (r_state == ST_WRITE_SHIFT) && !cs_n && sclk_pos;
    assign w_tx_load  = (r_state == ST_READ_LOAD)   && !cs_n;
    assign w_tx_shift = (r_state == ST_READ_SHIFT)  && !cs_n && sclk_neg;

    spi_shiftreg #(.WIDTH(DATA_W)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_sr_clr),
        .i_load  (1'b0),
        .i_pdata ({DATA_W{1'b0}}),
        .i_shift (w_rx_shift),
        .i_sin   (mosi),
        .o_pdata (w_rx_pdata),
        .o_sout  (w_rx_sout)
    );

    spi_shiftreg #(.WIDTH(DATA_W)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_sr_clr),
        .i_load  (w_tx_load),
        .i_pdata (mem_rdata),
        .i_shift (w_tx_shift),
        .i_sin   (1'b0),
        .o_pdata (w_tx_pdata),
        .o_sout  (w_tx_sout)
    );

    assign w_unused = ^{w_rx_sout, w_tx_pdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_cmd      <= '0;
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_miso_oe  <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_miso_oe <= 1'b0;
                    if (!cs_n) begin
                        r_state <= ST_GET_CMD;
                        r_cnt   <= '0;
                        r_cmd   <= '0;
                    end
                end
                ST_GET_CMD: begin
                    if (cs_n) begin
                        r_state <= ST_IDLE;
                    end else if (sclk_pos) begin
                        // Final command bit is R/W; address bits are already in r_cmd.
                        if (r_cnt == c_cmd_last) begin
                            r_mem_addr <= r_cmd;
                            r_cnt      <= '0;
                            r_state    <= mosi ? ST_READ_LOAD : ST_WRITE_SHIFT;
                        end else begin
                            r_cmd <= {r_cmd[ADDR_W-2:0], mosi};
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_READ_LOAD: begin
                    if (cs_n) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state   <= ST_READ_SHIFT;
                        r_miso_oe <= 1'b1;
                    end
                end
                ST_READ_SHIFT: begin
                    if (cs_n) begin
                        r_state   <= ST_IDLE;
                        r_miso_oe <= 1'b0;
                    end else if (sclk_neg) begin
                        if (r_cnt == c_data_last) begin
                            r_state   <= ST_DONE;
                            r_miso_oe <= 1'b0;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_WRITE_SHIFT: begin
                    if (cs_n) begin
                        r_state <= ST_IDLE;
                    end else if (sclk_pos) begin
                        if (r_cnt == c_data_last) begin
                            r_state  <= ST_WRITE_COMMIT;
                            r_mem_we <= 1'b1;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_WRITE_COMMIT: begin
                    r_state <= cs_n ? ST_IDLE : ST_DONE;
                end
                ST_DONE: begin
                    if (cs_n) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_miso_oe <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = w_rx_pdata;
    assign mem_we    = r_mem_we;
    assign miso_oe   = r_miso_oe;
    assign miso      = r_miso_oe & w_tx_sout;
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
